// File: rtl/adder_arbiter.sv
// Two-port round-robin front end for a shared, externally pipelined adder.
// Results return on the requesting port in acceptance order; supports flush.
module adder_arbiter #(
  parameter int WIDTH1 = 4,
  parameter int WIDTH2 = 4,
  parameter int LAT = 2,
  localparam int W = WIDTH1 + WIDTH2
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  output logic              res0_valid,
  output logic [W-1:0]      res0_data,
  output logic              res1_valid,
  output logic [W-1:0]      res1_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [WIDTH1-1:0] add_l1,
  output logic [WIDTH1-1:0] add_l2,
  output logic [WIDTH2-1:0] add_l3,
  output logic [WIDTH2-1:0] add_l4,
  output logic              add_aclr,
  input  logic [W-1:0]      add_sum,
  output logic              busy
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]   state;
  logic         prio;
  logic [LAT:0] tv;
  logic [LAT:0] tp;
  logic         run;
  logic         g0;
  logic         g1;
  logic         acc0;
  logic         acc1;
  logic         acc;
  logic [W-1:0] sa;
  logic [W-1:0] sb;

  // prio names the port that wins when both request
  assign run  = (state == RUN);
  assign g0   = req0_valid & (~req1_valid | ~prio);
  assign g1   = req1_valid & (~req0_valid | prio);
  assign req0_ready = run & g0;
  assign req1_ready = run & g1;
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc  = acc0 | acc1;
  assign sa   = acc1 ? req1_a : req0_a;
  assign sb   = acc1 ? req1_b : req0_b;

  assign busy     = ~run | (|tv);
  assign add_aclr = ~aclr_n | (state == CLEAR);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= RUN;
      prio       <= 1'b0;
      tv         <= '0;
      tp         <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_data  <= '0;
      res1_data  <= '0;
      add_l1     <= '0;
      add_l2     <= '0;
      add_l3     <= '0;
      add_l4     <= '0;
      flush_done <= 1'b0;
    end else begin
      tv <= {tv[LAT-1:0], acc};
      tp <= {tp[LAT-1:0], acc1};
      if (acc) begin
        prio   <= ~acc1;
        add_l1 <= sa[WIDTH1-1:0];
        add_l2 <= sb[WIDTH1-1:0];
        add_l3 <= sa[W-1:WIDTH1];
        add_l4 <= sb[W-1:WIDTH1];
      end
      // tag leaving the pipe lines up with the adder output
      res0_valid <= tv[LAT] & ~tp[LAT];
      res1_valid <= tv[LAT] & tp[LAT];
      if (tv[LAT] & ~tp[LAT]) res0_data <= add_sum;
      if (tv[LAT] & tp[LAT])  res1_data <= add_sum;
      flush_done <= (state == CLEAR);
      unique case (state)
        RUN:     if (flush_req) state <= DRAIN;
        DRAIN:   if (~|tv) state <= CLEAR;
        CLEAR:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
